// File: rtl/seq_sync_ctrl.sv
// Frame-synchronisation controller: turns per-bit pattern hits into a
// HUNT/VERIFY/LOCKED alignment decision with flywheel and loss detection.
module seq_sync_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int VERIFY_N  = 2,
    parameter int LOSS_N    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_valid,
    input  logic       hit,
    output logic       lock,
    output logic       frame_start,
    output logic       sync_loss,
    output logic [1:0] state,
    output logic [7:0] miss_total
);

    localparam int PW = $clog2(FRAME_LEN);
    localparam int GW = $clog2(VERIFY_N + 1);
    localparam int MW = $clog2(LOSS_N + 1);
    localparam logic [PW-1:0] LAST_POS = PW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } syncState;

    syncState       curState, nextState;
    logic [PW-1:0]  pos, posNext;
    logic [GW-1:0]  good, goodNext, goodInc;
    logic [MW-1:0]  miss, missNext, missInc;
    logic [7:0]     totalNext;
    logic           frameNext, lossNext, isSlot;

    assign goodInc = good + GW'(1);
    assign missInc = miss + MW'(1);
    assign isSlot  = bit_valid && (pos == LAST_POS);

    always_ff @(posedge clk) begin
        if (rst) begin
            curState    <= HUNT;
            pos         <= '0;
            good        <= '0;
            miss        <= '0;
            miss_total  <= '0;
            lock        <= 1'b0;
            frame_start <= 1'b0;
            sync_loss   <= 1'b0;
        end else begin
            curState    <= nextState;
            pos         <= posNext;
            good        <= goodNext;
            miss        <= missNext;
            miss_total  <= totalNext;
            lock        <= (nextState == LOCKED);
            frame_start <= frameNext;
            sync_loss   <= lossNext;
        end
    end

    // Slot decisions: the confirming VERIFY slot already counts as a frame
    // boundary, and the slot that drops lock produces sync_loss instead.
    always_comb begin
        nextState = curState;
        posNext   = pos;
        goodNext  = good;
        missNext  = miss;
        totalNext = miss_total;
        frameNext = 1'b0;
        lossNext  = 1'b0;
        if (bit_valid) begin
            posNext = (pos == LAST_POS) ? '0 : pos + PW'(1);
            case (curState)
                HUNT: begin
                    if (hit) begin
                        nextState = VERIFY;
                        posNext   = '0;
                        goodNext  = '0;
                    end
                end
                VERIFY: begin
                    if (isSlot) begin
                        if (hit) begin
                            goodNext = goodInc;
                            if (goodInc == GW'(VERIFY_N)) begin
                                nextState = LOCKED;
                                missNext  = '0;
                                frameNext = 1'b1;
                            end
                        end else begin
                            nextState = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (isSlot) begin
                        frameNext = 1'b1;
                        if (hit) begin
                            missNext = '0;
                        end else begin
                            missNext = missInc;
                            if (miss_total != 8'hFF)
                                totalNext = miss_total + 8'd1;
                            if (missInc == MW'(LOSS_N)) begin
                                nextState = HUNT;
                                lossNext  = 1'b1;
                                frameNext = 1'b0;
                            end
                        end
                    end
                end
                default: nextState = HUNT;
            endcase
        end
    end

    assign state = curState;

endmodule
